// File: rtl/word_match_sequencer_if.sv
// Handshake and score bus between the game control logic and word_match_sequencer.
// The master side drives target/guess/control; the slave side returns scores and status.
interface word_match_sequencer_if #(
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned SCORE_W = 17
);
    logic               target_load;
    logic [WORD_W-1:0]  target_in;
    logic               start;
    logic               abort;
    logic               guess_valid;
    logic               guess_ready;
    logic [WORD_W-1:0]  guess_in;
    logic               flag_in;
    logic [SCORE_W-1:0] round_score;
    logic               score_valid;
    logic [SCORE_W-1:0] total_score;
    logic [7:0]         round_cnt;
    logic               done;
    logic               busy;

    modport master (
        output target_load, target_in, start, abort, guess_valid, guess_in, flag_in,
        input  guess_ready, round_score, score_valid, total_score, round_cnt, done, busy
    );

    modport slave (
        input  target_load, target_in, start, abort, guess_valid, guess_in, flag_in,
        output guess_ready, round_score, score_valid, total_score, round_cnt, done, busy
    );
endinterface

// File: rtl/word_match_sequencer.sv
// Multi-round word-matching game sequencer: one guess per round, fixed-priority scoring and a
// saturating total. Optional macro STREAK_BONUS_EN adds +4 once three full matches run in a row.
module word_match_sequencer #(
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned SCORE_W = 17,
    parameter int unsigned ROUNDS  = 8
) (
    input logic                   clk,
    input logic                   reset,
    word_match_sequencer_if.slave bus_io
);
    localparam int unsigned HalfW = WORD_W / 2;

    typedef enum logic [2:0] {StIdle, StArmed, StCompare, StScore, StDone} state_e;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  target_q, target_d;
    logic [WORD_W-1:0]  guess_q, guess_d;
    logic               flag_q, flag_d;
    logic [2:0]         match_q, match_d;  // {full, first, second}
    logic [SCORE_W-1:0] round_score_q, round_score_d;
    logic [SCORE_W-1:0] total_q, total_d;
    logic [7:0]         round_cnt_q, round_cnt_d;
    logic               score_valid_q, score_valid_d;
    logic [SCORE_W-1:0] base_score, new_score;
    logic [SCORE_W:0]   sum;
    logic               idle_like, game_start;

    assign idle_like  = (state_q == StIdle) || (state_q == StDone);
    assign game_start = idle_like && bus_io.start && !bus_io.abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus_io.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: if (bus_io.start) state_d = StArmed;
                StArmed:        if (bus_io.guess_valid) state_d = StCompare;
                StCompare:      state_d = StScore;
                StScore:        state_d = (round_cnt_d == 8'(ROUNDS)) ? StDone : StArmed;
                default:        state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bus_io.guess_ready = (state_q == StArmed);
        bus_io.busy        = (state_q == StArmed) || (state_q == StCompare) ||
                             (state_q == StScore);
        bus_io.done        = (state_q == StDone);
        bus_io.round_score = round_score_q;
        bus_io.score_valid = score_valid_q;
        bus_io.total_score = total_q;
        bus_io.round_cnt   = round_cnt_q;
    end

    // The upper-half match bit never changes the score; it only falls through to the default.
    always_comb begin
        priority casez ({match_q, flag_q})
            4'b??11: base_score = SCORE_W'(10);
            4'b1???: base_score = SCORE_W'(8);
            4'b??1?: base_score = SCORE_W'(5);
            default: base_score = SCORE_W'(2);
        endcase
    end

`ifdef STREAK_BONUS_EN
    logic [1:0] streak_q, streak_d, streak_inc;

    always_comb begin
        streak_inc = match_q[2] ? ((streak_q == 2'd3) ? 2'd3 : streak_q + 2'd1) : 2'd0;
        streak_d   = streak_q;
        if (bus_io.abort || game_start) begin
            streak_d = 2'd0;
        end else if (state_q == StScore) begin
            streak_d = streak_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= 2'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign new_score = base_score + ((streak_inc == 2'd3) ? SCORE_W'(4) : SCORE_W'(0));
`else
    assign new_score = base_score;
`endif

    assign sum = {1'b0, total_q} + {1'b0, new_score};

    always_comb begin
        target_d      = target_q;
        guess_d       = guess_q;
        flag_d        = flag_q;
        match_d       = match_q;
        round_score_d = round_score_q;
        total_d       = total_q;
        round_cnt_d   = round_cnt_q;
        score_valid_d = 1'b0;
        if (!bus_io.abort) begin
            if (idle_like && bus_io.target_load) target_d = bus_io.target_in;
            if (game_start) begin
                total_d     = '0;
                round_cnt_d = '0;
            end
            if (state_q == StArmed && bus_io.guess_valid) begin
                guess_d = bus_io.guess_in;
                flag_d  = bus_io.flag_in;
            end
            if (state_q == StCompare) begin
                match_d = {guess_q == target_q,
                           guess_q[WORD_W-1:HalfW] == target_q[WORD_W-1:HalfW],
                           guess_q[HalfW-1:0] == target_q[HalfW-1:0]};
            end
            if (state_q == StScore) begin
                round_score_d = new_score;
                total_d       = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
                round_cnt_d   = round_cnt_q + 8'd1;
                score_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q      <= '0;
            guess_q       <= '0;
            flag_q        <= 1'b0;
            match_q       <= '0;
            round_score_q <= '0;
            total_q       <= '0;
            round_cnt_q   <= '0;
            score_valid_q <= 1'b0;
        end else begin
            target_q      <= target_d;
            guess_q       <= guess_d;
            flag_q        <= flag_d;
            match_q       <= match_d;
            round_score_q <= round_score_d;
            total_q       <= total_d;
            round_cnt_q   <= round_cnt_d;
            score_valid_q <= score_valid_d;
        end
    end
endmodule
